kbd_disp_port: RTL and testbench

//  Pad-side end of the CPU keyboard/display interface: the responder that services CPU
//  en_inp reads and en_out writes. Keyboard bytes from pads are synchronised, strobe-

---
 rtl/kbd_disp_port.sv | 197 +++++++++++++++++++
 tb/tb_kbd_disp_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_disp_port.sv
// kbd_disp_port: pad-side responder for CPU keyboard reads (en_inp) and display writes (en_out).
// Keyboard bytes are synchronised, strobe-edge qualified and queued in a small FIFO.
// Display writes drive disp_pad with a timed strobe followed by a hold window.
// Optional feature: define KBD_IRQ_EN to enable a registered keyboard interrupt on kbd_irq;
// when undefined kbd_irq is tied low and no extra flops are built.
module kbd_disp_port #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STB_CYC    = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clkin,
  input  logic        rstn,
  input  logic [7:0]  kbd_pad,
  input  logic        kbd_stb_pad,
  input  logic        en_inp,
  input  logic        en_out,
  input  logic [7:0]  cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic [7:0]  disp_pad,
  output logic        disp_stb_pad,
  output logic        kbd_irq
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMR_MAX = (STB_CYC > HOLD_CYC) ? STB_CYC : HOLD_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_HOLD   = 2'd2
  } disp_state_t;

  // Synchroniser and enable-edge registers
  logic [7:0] kbd_s1, kbd_s2;
  logic       stb_s1, stb_s2, stb_s3;
  logic       en_inp_d, en_out_d;

  // FIFO state
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_n;
  logic             kbd_ovf, kbd_ovf_n;
  logic             disp_ovf, disp_ovf_n;

  // Display FSM state
  disp_state_t      state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [7:0]       disp_pad_n;
  logic             disp_stb_n;

  logic kbd_push, rd_edge, wr_edge;
  logic fifo_empty, fifo_full, do_pop, do_push, push_drop;
  logic disp_busy, disp_drop;
  logic [7:0] head;

  assign kbd_push = stb_s2 & ~stb_s3;
  assign rd_edge  = en_inp & ~en_inp_d;
  assign wr_edge  = en_out & ~en_out_d;

  // Two-flop synchronisers on pad inputs, third strobe flop for edge detect, enable history
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      kbd_s1   <= 8'h00;
      kbd_s2   <= 8'h00;
      stb_s1   <= 1'b0;
      stb_s2   <= 1'b0;
      stb_s3   <= 1'b0;
      en_inp_d <= 1'b0;
      en_out_d <= 1'b0;
    end else begin
      kbd_s1   <= kbd_pad;
      kbd_s2   <= kbd_s1;
      stb_s1   <= kbd_stb_pad;
      stb_s2   <= stb_s1;
      stb_s3   <= stb_s2;
      en_inp_d <= en_inp;
      en_out_d <= en_out;
    end
  end

  // FIFO push/pop arbitration and sticky overflow flags (a new event wins over read-clear)
  always_comb begin
    fifo_empty = (fifo_cnt == CNT_W'(0));
    fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    do_pop     = rd_edge & ~fifo_empty;
    do_push    = kbd_push & (~fifo_full | do_pop);
    push_drop  = kbd_push & fifo_full & ~do_pop;

    wr_ptr_n   = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n   = do_pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    fifo_cnt_n = fifo_cnt + CNT_W'(do_push) - CNT_W'(do_pop);

    kbd_ovf_n  = kbd_ovf;
    disp_ovf_n = disp_ovf;
    if (rd_edge) begin
      kbd_ovf_n  = 1'b0;
      disp_ovf_n = 1'b0;
    end
    if (push_drop) kbd_ovf_n  = 1'b1;
    if (disp_drop) disp_ovf_n = 1'b1;
  end

  // FIFO pointer, count and flag registers
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      kbd_ovf  <= 1'b0;
      disp_ovf <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      fifo_cnt <= fifo_cnt_n;
      kbd_ovf  <= kbd_ovf_n;
      disp_ovf <= disp_ovf_n;
    end
  end

  // FIFO storage; contents are don't-care while the slot is not counted as valid
  always_ff @(posedge clkin) begin
    if (do_push) mem[wr_ptr] <= kbd_s2;
  end

  // Display FSM next-state: latch byte, strobe for STB_CYC, hold for HOLD_CYC
  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    disp_pad_n = disp_pad;
    disp_stb_n = disp_stb_pad;
    disp_busy  = (state != S_IDLE);
    disp_drop  = wr_edge & (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (wr_edge) begin
          disp_pad_n = cpu_wdata;
          disp_stb_n = 1'b1;
          tmr_n      = TMR_W'(STB_CYC - 1);
          state_n    = S_STROBE;
        end
      end
      S_STROBE: begin
        if (tmr == TMR_W'(0)) begin
          disp_stb_n = 1'b0;
          tmr_n      = TMR_W'(HOLD_CYC - 1);
          state_n    = S_HOLD;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      S_HOLD: begin
        if (tmr == TMR_W'(0)) begin
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      default: begin
        state_n    = S_IDLE;
        disp_stb_n = 1'b0;
        tmr_n      = '0;
      end
    endcase
  end

  // Display FSM state and pad registers
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      tmr          <= '0;
      disp_pad     <= 8'h00;
      disp_stb_pad <= 1'b0;
    end else begin
      state        <= state_n;
      tmr          <= tmr_n;
      disp_pad     <= disp_pad_n;
      disp_stb_pad <= disp_stb_n;
    end
  end

  // Status word is a pure decode of registers so the CPU sees it with no added latency
  assign head      = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign cpu_rdata = {~fifo_empty, kbd_ovf, disp_ovf, disp_busy, 4'h0, head};

`ifdef KBD_IRQ_EN
  // Interrupt tracks the post-update FIFO occupancy and overflow flag
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) kbd_irq <= 1'b0;
    else       kbd_irq <= (fifo_cnt_n != CNT_W'(0)) | kbd_ovf_n;
  end
`else
  assign kbd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_disp_port.sv
// Bench for kbd_disp_port: table vectors, hand sequences for FIFO/reset corners,
// and randomized traffic compared each cycle against a queue-based reference model.
module tb_kbd_disp_port;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned STB   = 4;
  localparam int unsigned HOLD  = 2;

  logic        clkin = 1'b0;
  logic        rstn  = 1'b0;
  logic [7:0]  kbd_pad = 8'h00;
  logic        kbd_stb_pad = 1'b0;
  logic        en_inp = 1'b0;
  logic        en_out = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [15:0] cpu_rdata;
  logic [7:0]  disp_pad;
  logic        disp_stb_pad;
  logic        kbd_irq;

  always #5 clkin = ~clkin;

  kbd_disp_port #(.FIFO_DEPTH(DEPTH), .STB_CYC(STB), .HOLD_CYC(HOLD)) dut (
    .clkin(clkin), .rstn(rstn), .kbd_pad(kbd_pad), .kbd_stb_pad(kbd_stb_pad),
    .en_inp(en_inp), .en_out(en_out), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .disp_pad(disp_pad), .disp_stb_pad(disp_stb_pad), .kbd_irq(kbd_irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: keyboard queue, a 2-edge pad latency line, busy countdown for display
  logic [7:0] q[$];
  logic       pv0, pv1;
  logic [7:0] pd0, pd1;
  logic       m_prev_stb, m_prev_inp, m_prev_out;
  logic       m_kovf, m_dovf;
  int         busy_left;
  logic [7:0] m_pad;

  function automatic void model_reset();
    q.delete();
    pv0 = 1'b0; pv1 = 1'b0; pd0 = 8'h00; pd1 = 8'h00;
    m_prev_stb = 1'b0; m_prev_inp = 1'b0; m_prev_out = 1'b0;
    m_kovf = 1'b0; m_dovf = 1'b0; busy_left = 0; m_pad = 8'h00;
  endfunction

  function automatic void model_step();
    logic       push_now, rd, wr, popok, was_full;
    logic [7:0] push_byte;
    push_now  = pv1;
    push_byte = pd1;
    pv1 = pv0; pd1 = pd0;
    pv0 = kbd_stb_pad && !m_prev_stb;
    pd0 = kbd_pad;
    m_prev_stb = kbd_stb_pad;
    rd = en_inp && !m_prev_inp; m_prev_inp = en_inp;
    wr = en_out && !m_prev_out; m_prev_out = en_out;

    was_full = (q.size() == DEPTH);
    popok    = rd && (q.size() > 0);
    if (rd) begin m_kovf = 1'b0; m_dovf = 1'b0; end
    if (popok) void'(q.pop_front());
    if (push_now) begin
      if (was_full && !popok) m_kovf = 1'b1;
      else q.push_back(push_byte);
    end

    if (busy_left > 0) begin
      busy_left--;
      if (wr) m_dovf = 1'b1;
    end else if (wr) begin
      busy_left = STB + HOLD;
      m_pad     = cpu_wdata;
    end
  endfunction

  function automatic logic [15:0] exp_rdata();
    logic [7:0] h;
    h = (q.size() > 0) ? q[0] : 8'h00;
    return {(q.size() > 0), m_kovf, m_dovf, (busy_left > 0), 4'h0, h};
  endfunction

  function automatic logic exp_irq();
`ifdef KBD_IRQ_EN
    return (q.size() > 0) || m_kovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rdata"}, cpu_rdata, exp_rdata());
    chk({tag, ".pad"},   16'(disp_pad), 16'(m_pad));
    chk({tag, ".stb"},   16'(disp_stb_pad), 16'(busy_left > HOLD));
    chk({tag, ".irq"},   16'(kbd_irq), 16'(exp_irq()));
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    model_step();
    check_model("model");
  endtask

  task automatic set_in(input logic ei, input logic eo, input logic stb,
                        input logic [7:0] kb, input logic [7:0] wd);
    en_inp = ei; en_out = eo; kbd_stb_pad = stb; kbd_pad = kb; cpu_wdata = wd;
  endtask

  task automatic push_key(input logic [7:0] b);
    set_in(1'b0, 1'b0, 1'b1, b, 8'h00); tick();
    set_in(1'b0, 1'b0, 1'b0, b, 8'h00); tick();
  endtask

  task automatic cpu_read(input string name, input logic [15:0] exp);
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); tick();
    chk(name, cpu_rdata, exp);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); tick();
  endtask

  typedef struct {
    logic        ei, eo, stb;
    logic [7:0]  kbd, wd;
    logic [15:0] rd;
    logic [7:0]  pad;
    logic        pstb, irq;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h41, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h41, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h41, 8'h00, 16'h8041, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 16'h1000, 8'h5A, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h1000, 8'h5A, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 16'h3000, 8'h5A, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h3000, 8'h5A, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h3000, 8'h5A, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h3000, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h2000, 8'h5A, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h5A, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h5A, 1'b0, 1'b0};

    // Reset state
    model_reset();
    #12;
    check_model("reset");
    @(posedge clkin); #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Table: key 0x41 then read; display write with an overlapping second write
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].ei, tbl[i].eo, tbl[i].stb, tbl[i].kbd, tbl[i].wd);
      tick();
      chk($sformatf("tbl%0d.rdata", i), cpu_rdata, tbl[i].rd);
      chk($sformatf("tbl%0d.pad", i),   16'(disp_pad), 16'(tbl[i].pad));
      chk($sformatf("tbl%0d.stb", i),   16'(disp_stb_pad), 16'(tbl[i].pstb));
`ifdef KBD_IRQ_EN
      chk($sformatf("tbl%0d.irq", i),   16'(kbd_irq), 16'(tbl[i].irq));
`else
      chk($sformatf("tbl%0d.irq", i),   16'(kbd_irq), 16'h0000);
`endif
    end

    // Overflow: five pushes into a four-deep FIFO, then drain
    for (int b = 1; b <= 5; b++) push_key(8'(b));
    tick(); tick();
    chk("ovf.full", cpu_rdata, 16'hC001);
    cpu_read("ovf.rd1", 16'h8002);
    cpu_read("ovf.rd2", 16'h8003);
    cpu_read("ovf.rd3", 16'h8004);
    cpu_read("ovf.rd4", 16'h0000);
    cpu_read("ovf.rd_empty", 16'h0000);

    // Full FIFO with push and pop on the same edge: no overflow, count unchanged
    for (int b = 0; b < 4; b++) push_key(8'h11 + 8'(b));
    tick(); tick();
    chk("both.full", cpu_rdata, 16'h8011);
    set_in(1'b0, 1'b0, 1'b1, 8'h15, 8'h00); tick();
    set_in(1'b0, 1'b0, 1'b0, 8'h15, 8'h00); tick();
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); tick();
    chk("both.same_edge", cpu_rdata, 16'h8012);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); tick();
    cpu_read("both.rd1", 16'h8013);
    cpu_read("both.rd2", 16'h8014);
    cpu_read("both.rd3", 16'h8015);
    cpu_read("both.rd4", 16'h0000);

    // Asynchronous reset in the middle of a display strobe
    push_key(8'h77);
    tick(); tick();
    set_in(1'b0, 1'b1, 1'b0, 8'h00, 8'hC3); tick();
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); tick();
    chk("mid.stb_before", 16'(disp_stb_pad), 16'h0001);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst.stb",   16'(disp_stb_pad), 16'h0000);
    chk("rst.pad",   16'(disp_pad), 16'h0000);
    chk("rst.rdata", cpu_rdata, 16'h0000);
    chk("rst.irq",   16'(kbd_irq), 16'h0000);
    @(posedge clkin); #1;
    check_model("rst_hold");
    rstn = 1'b1;
    tick(); tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
